xif_aes_sequencer: RTL and testbench

XIF_AES_SEQUENCER -- requirements
Module: xif_aes_sequencer

---
 rtl/xif_aes_sequencer_pkg.sv | 55 +++++
 rtl/xif_aes_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_xif_aes_sequencer.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xif_aes_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : xif_aes_sequencer_pkg
// Purpose  : Shared AES32 decode constants, queue types and FSM states.
// Revision : 1.0
// ============================================================================
package xif_aes_sequencer_pkg;

    localparam logic [6:0] AES32     = 7'b0110011;
    localparam logic [4:0] AES32ESI  = 5'b10001;
    localparam logic [4:0] AES32ESMI = 5'b10011;
    localparam logic [4:0] AES32DSI  = 5'b10101;
    localparam logic [4:0] AES32DSMI = 5'b10111;

    typedef enum logic [1:0] {
        PEND      = 2'd0,
        COMMITTED = 2'd1,
        KILLED    = 2'd2
    } entry_status_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } seq_state_e;

    // The instruction id lives beside this struct because its width is a
    // parameter of the sequencer.
    typedef struct packed {
        entry_status_e status;
        logic [31:0]   rs1;
        logic [31:0]   rs2;
        logic [1:0]    bs;
        logic [3:0]    op;
        logic [4:0]    rd;
    } entry_t;

    // One-hot {encsm, encs, decsm, decs}; zero when the word is not AES32.
    function automatic logic [3:0] aes32_op(input logic [31:0] instr);
        logic [3:0] op;
        op = 4'b0000;
        if (instr[6:0] == AES32) begin
            case (instr[29:25])
                AES32ESMI: op = 4'b1000;
                AES32ESI:  op = 4'b0100;
                AES32DSMI: op = 4'b0010;
                AES32DSI:  op = 4'b0001;
                default:   op = 4'b0000;
            endcase
        end
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/xif_aes_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : xif_aes_sequencer
// Purpose  : In-order XIF offload queue that feeds an external AES32 unit.
//            Macro XIF_AES_SEQ_SPEC_EXEC_EN allows dispatch of uncommitted heads.
// Revision : 1.0
// ============================================================================
module xif_aes_sequencer
    import xif_aes_sequencer_pkg::*;
#(
    parameter int X_ID_WIDTH = 4,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue_valid_i,
    output logic                  issue_ready_o,
    input  logic [31:0]           issue_instr_i,
    input  logic [X_ID_WIDTH-1:0] issue_id_i,
    input  logic [31:0]           issue_rs1_i,
    input  logic [31:0]           issue_rs2_i,
    output logic                  issue_accept_o,
    input  logic                  commit_valid_i,
    input  logic [X_ID_WIDTH-1:0] commit_id_i,
    input  logic                  commit_kill_i,
    output logic                  fu_valid_o,
    output logic [31:0]           fu_rs1_o,
    output logic [31:0]           fu_rs2_o,
    output logic [1:0]            fu_bs_o,
    output logic [3:0]            fu_op_o,
    input  logic                  fu_ready_i,
    input  logic [31:0]           fu_rd_i,
    output logic                  result_valid_o,
    input  logic                  result_ready_i,
    output logic [X_ID_WIDTH-1:0] result_id_o,
    output logic [31:0]           result_data_o,
    output logic [4:0]            result_rd_o,
    output logic                  result_we_o
);

    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int               CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    entry_t                entry_q [DEPTH];
    logic [X_ID_WIDTH-1:0] id_q    [DEPTH];
    logic [DEPTH-1:0]      valid_q;
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    seq_state_e            state_q;
    logic [X_ID_WIDTH-1:0] res_id_q;
    logic [31:0]           res_data_q;
    logic [4:0]            res_rd_q;

    logic [3:0]    w_issue_op;
    entry_status_e w_issue_status;
    entry_t        w_head;
    logic          w_head_vld;
    logic          w_push;
    logic          w_pop;
    logic          w_unused;

    assign w_issue_op     = aes32_op(issue_instr_i);
    assign issue_ready_o  = (count_q != FULL_CNT);
    assign issue_accept_o = issue_valid_i & issue_ready_o & (w_issue_op != 4'b0000);
    assign w_push         = issue_accept_o;
    assign w_head         = entry_q[rd_ptr_q];
    assign w_head_vld     = valid_q[rd_ptr_q];
    assign w_unused       = ^issue_instr_i[24:12];

    // A commit for the id being enqueued lands directly in the new entry.
    always_comb begin
        w_issue_status = PEND;
        if (commit_valid_i && (commit_id_i == issue_id_i)) begin
            w_issue_status = commit_kill_i ? KILLED : COMMITTED;
        end
    end

    always_comb begin
        w_pop = 1'b0;
        case (state_q)
            IDLE: w_pop = w_head_vld && (w_head.status == KILLED);
`ifdef XIF_AES_SEQ_SPEC_EXEC_EN
            EXEC: w_pop = fu_ready_i && (w_head.status == KILLED);
            RESP: w_pop = (w_head.status == KILLED) ||
                          ((w_head.status == COMMITTED) && result_ready_i);
`else
            RESP: w_pop = result_ready_i;
`endif
            default: w_pop = 1'b0;
        endcase
    end

    // Payload storage needs no reset: valid_q alone decides occupancy.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && commit_valid_i && (id_q[i] == commit_id_i)) begin
                entry_q[i].status <= commit_kill_i ? KILLED : COMMITTED;
            end
        end
        if (w_push) begin
            entry_q[wr_ptr_q] <= '{status: w_issue_status,
                                   rs1:    issue_rs1_i,
                                   rs2:    issue_rs2_i,
                                   bs:     issue_instr_i[31:30],
                                   op:     w_issue_op,
                                   rd:     issue_instr_i[11:7]};
            id_q[wr_ptr_q]    <= issue_id_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_pop) begin
                valid_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q          <= rd_ptr_q + 1'b1;
            end
            if (w_push) begin
                valid_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q          <= wr_ptr_q + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            res_id_q   <= '0;
            res_data_q <= '0;
            res_rd_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
`ifdef XIF_AES_SEQ_SPEC_EXEC_EN
                    if (w_head_vld && (w_head.status != KILLED)) begin
                        state_q <= EXEC;
                    end
`else
                    if (w_head_vld && (w_head.status == COMMITTED)) begin
                        state_q <= EXEC;
                    end
`endif
                end
                EXEC: begin
                    if (fu_ready_i) begin
                        if (w_pop) begin
                            state_q <= IDLE;
                        end else begin
                            state_q    <= RESP;
                            res_id_q   <= id_q[rd_ptr_q];
                            res_data_q <= fu_rd_i;
                            res_rd_q   <= w_head.rd;
                        end
                    end
                end
                RESP: begin
                    if (w_pop) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fu_valid_o = (state_q == EXEC);
    assign fu_rs1_o   = fu_valid_o ? w_head.rs1 : '0;
    assign fu_rs2_o   = fu_valid_o ? w_head.rs2 : '0;
    assign fu_bs_o    = fu_valid_o ? w_head.bs  : '0;
    assign fu_op_o    = fu_valid_o ? w_head.op  : '0;

`ifdef XIF_AES_SEQ_SPEC_EXEC_EN
    // A speculatively executed head only writes back once it is committed.
    assign result_valid_o = (state_q == RESP) && (w_head.status == COMMITTED);
`else
    assign result_valid_o = (state_q == RESP);
`endif
    assign result_we_o    = result_valid_o;
    assign result_id_o    = res_id_q;
    assign result_data_o  = res_data_q;
    assign result_rd_o    = res_rd_q;

endmodule
`default_nettype wire

// File: tb/tb_xif_aes_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_xif_aes_sequencer
// Purpose  : Scoreboard bench for xif_aes_sequencer with a transaction model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_xif_aes_sequencer;

    localparam int X_ID_WIDTH = 4;
    localparam int DEPTH      = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue_valid = 1'b0;
    logic        issue_ready;
    logic [31:0] issue_instr = '0;
    logic [3:0]  issue_id = '0;
    logic [31:0] issue_rs1 = '0;
    logic [31:0] issue_rs2 = '0;
    logic        issue_accept;
    logic        commit_valid = 1'b0;
    logic [3:0]  commit_id = '0;
    logic        commit_kill = 1'b0;
    logic        fu_valid;
    logic [31:0] fu_rs1, fu_rs2;
    logic [1:0]  fu_bs;
    logic [3:0]  fu_op;
    logic        fu_ready;
    logic [31:0] fu_rd;
    logic        result_valid;
    logic        result_ready;
    logic [3:0]  result_id;
    logic [31:0] result_data;
    logic [4:0]  result_rd;
    logic        result_we;

    xif_aes_sequencer #(.X_ID_WIDTH(X_ID_WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
        .issue_instr_i(issue_instr), .issue_id_i(issue_id),
        .issue_rs1_i(issue_rs1), .issue_rs2_i(issue_rs2),
        .issue_accept_o(issue_accept),
        .commit_valid_i(commit_valid), .commit_id_i(commit_id), .commit_kill_i(commit_kill),
        .fu_valid_o(fu_valid), .fu_rs1_o(fu_rs1), .fu_rs2_o(fu_rs2),
        .fu_bs_o(fu_bs), .fu_op_o(fu_op), .fu_ready_i(fu_ready), .fu_rd_i(fu_rd),
        .result_valid_o(result_valid), .result_ready_i(result_ready),
        .result_id_o(result_id), .result_data_o(result_data),
        .result_rd_o(result_rd), .result_we_o(result_we)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [1:0]  bs;
        logic [3:0]  op;
        logic [4:0]  rd;
        int          st;   // 0 pending, 1 committed, 2 killed
    } mentry_t;

    mentry_t model_q[$];
    mentry_t fu_exp_q[$];
    mentry_t res_exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int fu_mode  = 1;      // 0 never ready, 1 always ready, 2 random
    int rr_mode  = 1;
    logic [3:0] next_id = '0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endfunction

    function automatic logic [3:0] ref_op(input logic [31:0] instr);
        if (instr[6:0] != 7'h33) return 4'b0000;
        case (instr[29:25])
            5'b10001: return 4'b0100;   // aes32esi  -> encs
            5'b10011: return 4'b1000;   // aes32esmi -> encsm
            5'b10101: return 4'b0001;   // aes32dsi  -> decs
            5'b10111: return 4'b0010;   // aes32dsmi -> decsm
            default:  return 4'b0000;
        endcase
    endfunction

    // Stand-in AES unit: any deterministic mix of the operands will do.
    function automatic logic [31:0] fu_func(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] bs, input logic [3:0] op);
        int          sh;
        logic [31:0] r;
        sh = 8 * int'(bs);
        r  = (sh == 0) ? b : ((b << sh) | (b >> (32 - sh)));
        return a ^ r ^ {op, 28'h0};
    endfunction

    function automatic logic [31:0] mk_aes(input int k, input logic [1:0] bs, input logic [4:0] rd);
        logic [4:0]  f5;
        logic [12:0] mid;
        case (k % 4)
            0:       f5 = 5'b10001;
            1:       f5 = 5'b10011;
            2:       f5 = 5'b10101;
            default: f5 = 5'b10111;
        endcase
        mid = 13'($urandom);
        return {bs, f5, mid, rd, 7'h33};
    endfunction

    // Resolved heads leave the model in program order; committed ones are owed.
    function automatic void drain();
        while (model_q.size() != 0 && model_q[0].st != 0) begin
            if (model_q[0].st == 1) begin
                fu_exp_q.push_back(model_q[0]);
                res_exp_q.push_back(model_q[0]);
            end
            void'(model_q.pop_front());
        end
    endfunction

    task automatic drive(input logic v, input logic [31:0] instr, input logic [3:0] id,
                         input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic cv, input logic [3:0] cid, input logic ck,
                         output logic acc);
        logic    exp_acc;
        mentry_t e;
        issue_valid  = v;
        issue_instr  = instr;
        issue_id     = id;
        issue_rs1    = rs1;
        issue_rs2    = rs2;
        commit_valid = cv;
        commit_id    = cid;
        commit_kill  = ck;
        #1;
        exp_acc = v && issue_ready && (ref_op(instr) != 4'b0000);
        chk("issue_accept", issue_accept, exp_acc);
        acc = issue_accept;
        if (exp_acc) begin
            e.id = id; e.rs1 = rs1; e.rs2 = rs2; e.bs = instr[31:30];
            e.op = ref_op(instr); e.rd = instr[11:7]; e.st = 0;
            model_q.push_back(e);
        end
        if (cv) begin
            foreach (model_q[i]) if (model_q[i].id == cid) model_q[i].st = ck ? 2 : 1;
        end
        drain();
        @(negedge clk);
        issue_valid  = 1'b0;
        commit_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((model_q.size() != 0 || res_exp_q.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_drain"}, (n < 400), 1'b1);
        repeat (4) @(negedge clk);
    endtask

    // FU and writeback responders.
    initial begin
        fu_ready = 1'b0; fu_rd = '0; result_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (fu_mode)
                0:       fu_ready = 1'b0;
                1:       fu_ready = 1'b1;
                default: fu_ready = ($urandom % 3) != 0;
            endcase
            fu_rd = fu_func(fu_rs1, fu_rs2, fu_bs, fu_op);
            case (rr_mode)
                0:       result_ready = 1'b0;
                1:       result_ready = 1'b1;
                default: result_ready = ($urandom % 3) != 0;
            endcase
        end
    end

    // Monitor: consumes expectations whenever the DUT completes a handshake.
    initial begin : monitor
        logic        pf, pr;
        logic [31:0] p_rs1, p_rs2, p_data;
        logic [1:0]  p_bs;
        logic [3:0]  p_op, p_id;
        logic [4:0]  p_rd;
        mentry_t     e;
        pf = 1'b0; pr = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                pf = 1'b0; pr = 1'b0;
                continue;
            end
            if (pf) begin
                chk("fu_hold_ops", {fu_rs1, fu_rs2}, {p_rs1, p_rs2});
                chk("fu_hold_ctl", {fu_valid, fu_bs, fu_op}, {1'b1, p_bs, p_op});
            end
            if (pr) chk("result_hold", {result_valid, result_id, result_rd, result_data},
                        {1'b1, p_id, p_rd, p_data});
            if (fu_valid && fu_ready) begin
                chk("fu_dispatch_expected", (fu_exp_q.size() != 0), 1'b1);
                if (fu_exp_q.size() != 0) begin
                    e = fu_exp_q.pop_front();
                    chk("fu_operands", {fu_rs1, fu_rs2}, {e.rs1, e.rs2});
                    chk("fu_bs_op", {fu_bs, fu_op}, {e.bs, e.op});
                end
            end
            if (result_valid && result_ready) begin
                chk("result_expected", (res_exp_q.size() != 0), 1'b1);
                if (res_exp_q.size() != 0) begin
                    e = res_exp_q.pop_front();
                    chk("result", {result_we, result_id, result_rd, result_data},
                        {1'b1, e.id, e.rd, fu_func(e.rs1, e.rs2, e.bs, e.op)});
                end
            end
            pf = fu_valid && !fu_ready;
            p_rs1 = fu_rs1; p_rs2 = fu_rs2; p_bs = fu_bs; p_op = fu_op;
            pr = result_valid && !result_ready;
            p_id = result_id; p_rd = result_rd; p_data = result_data;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: run did not complete, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin : stimulus
        logic acc;
        logic seen;
        int   n;
        int   pend[$];
        logic [31:0] instr;
        logic        v, cv, ck;
        logic [3:0]  cid;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_ready_accept", {issue_ready, issue_accept}, 2'b10);
        chk("reset_fu", {fu_valid, fu_bs, fu_op, fu_rs1, fu_rs2}, '0);
        chk("reset_result", {result_valid, result_we, result_id, result_rd, result_data}, '0);

        // Minimum-latency aes32esi, committed with its issue.
        drive(1'b1, {2'd2, 5'b10001, 13'h0, 5'd5, 7'h33}, 4'd3, 32'h00112233, 32'h44556677,
              1'b1, 4'd3, 1'b0, acc);
        chk("lat_t1", {fu_valid, result_valid}, 2'b00);
        @(negedge clk);
        chk("lat_t2_fu", {fu_valid, fu_op, fu_bs, result_valid}, {1'b1, 4'b0100, 2'd2, 1'b0});
        @(negedge clk);
        chk("lat_t3_result", {result_valid, result_id, result_rd}, {1'b1, 4'd3, 5'd5});
        wait_drain("latency");

        // Fill with pending entries, probe full, then commit in order.
        fu_mode = 2;
        for (int i = 0; i < DEPTH; i++)
            drive(1'b1, mk_aes(i, 2'(i), 5'(i + 1)), 4'(i), $urandom, $urandom, 1'b0, 4'd0, 1'b0, acc);
        chk("full_not_ready", issue_ready, 1'b0);
        drive(1'b1, mk_aes(0, 2'd1, 5'd9), 4'd4, $urandom, $urandom, 1'b0, 4'd0, 1'b0, acc);
        chk("fifth_not_taken", acc, 1'b0);
        for (int i = 0; i < DEPTH; i++)
            drive(1'b0, 32'h0, 4'd0, 32'h0, 32'h0, 1'b1, 4'(i), 1'b0, acc);
        wait_drain("fill");

        // Kill one, commit the other.
        drive(1'b1, mk_aes(1, 2'd3, 5'd11), 4'd1, $urandom, $urandom, 1'b0, 4'd0, 1'b0, acc);
        drive(1'b1, mk_aes(2, 2'd0, 5'd12), 4'd2, $urandom, $urandom, 1'b0, 4'd0, 1'b0, acc);
        drive(1'b0, 32'h0, 4'd0, 32'h0, 32'h0, 1'b1, 4'd1, 1'b1, acc);
        drive(1'b0, 32'h0, 4'd0, 32'h0, 32'h0, 1'b1, 4'd2, 1'b0, acc);
        wait_drain("kill");

        // Non-AES words are refused and never reach the FU.
        drive(1'b1, {2'd1, 5'b00000, 13'h0, 5'd3, 7'h33}, 4'd5, $urandom, $urandom, 1'b0, 4'd0, 1'b0, acc);
        drive(1'b1, {2'd1, 5'b10001, 13'h0, 5'd3, 7'h13}, 4'd5, $urandom, $urandom, 1'b1, 4'd5, 1'b0, acc);
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | fu_valid | result_valid;
        end
        chk("nonaes_idle", {issue_ready, seen}, 2'b10);

        // Writeback back-pressure.
        rr_mode = 0; fu_mode = 1;
        @(negedge clk);
        drive(1'b1, mk_aes(3, 2'd1, 5'd20), 4'd5, $urandom, $urandom, 1'b1, 4'd5, 1'b0, acc);
        drive(1'b1, mk_aes(0, 2'd2, 5'd21), 4'd6, $urandom, $urandom, 1'b1, 4'd6, 1'b0, acc);
        n = 0;
        while (!result_valid && n < 20) begin @(negedge clk); n++; end
        chk("bp_result_seen", result_valid, 1'b1);
        repeat (5) @(negedge clk);
        chk("bp_held", {result_valid, result_id, fu_valid}, {1'b1, 4'd5, 1'b0});
        rr_mode = 1;
        n = 0;
        while (!fu_valid && n < 20) begin @(negedge clk); n++; end
        chk("bp_next_dispatch", fu_valid, 1'b1);
        wait_drain("backpressure");

        // Reset while the head is stuck in EXEC with three entries queued.
        fu_mode = 0;
        @(negedge clk);
        for (int i = 7; i < 10; i++)
            drive(1'b1, mk_aes(i, 2'(i), 5'(i)), 4'(i), $urandom, $urandom, 1'b1, 4'(i), 1'b0, acc);
        n = 0;
        while (!fu_valid && n < 20) begin @(negedge clk); n++; end
        chk("rst_in_exec", fu_valid, 1'b1);
        rst_n = 1'b0;
        model_q.delete(); fu_exp_q.delete(); res_exp_q.delete();
        #1;
        chk("rst_mid_fu", {fu_valid, fu_bs, fu_op, fu_rs1, fu_rs2}, '0);
        chk("rst_mid_result", {result_valid, result_we, result_id, result_rd, result_data}, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        fu_mode = 1;
        @(negedge clk);
        chk("rst_release_ready", issue_ready, 1'b1);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen = seen | fu_valid | result_valid;
        end
        chk("rst_no_stale", seen, 1'b0);

        // Randomized traffic against the transaction model.
        fu_mode = 2; rr_mode = 2;
        next_id = 4'd0;
        for (int c = 0; c < 800; c++) begin
            v = ($urandom % 3) != 0;
            instr = $urandom;
            if ($urandom % 5 != 0) instr = mk_aes(int'($urandom % 4), instr[31:30], instr[11:7]);
            else if ($urandom % 2 == 0) instr[6:0] = 7'h33;
            cv = 1'b0; ck = 1'b0; cid = 4'd0;
            if ($urandom % 3 == 0) begin
                pend.delete();
                foreach (model_q[i]) if (model_q[i].st == 0) pend.push_back(i);
                cv = 1'b1;
                ck = ($urandom % 4) == 0;
                if (pend.size() != 0 && ($urandom % 4) != 0)
                    cid = model_q[pend[$urandom_range(pend.size() - 1)]].id;
                else
                    cid = next_id;
            end
            drive(v, instr, next_id, $urandom, $urandom, cv, cid, ck, acc);
            if (acc) next_id = next_id + 4'd1;
        end
        n = 0;
        while (model_q.size() != 0 && n < 50) begin
            drive(1'b0, 32'h0, 4'd0, 32'h0, 32'h0, 1'b1, model_q[0].id, 1'($urandom % 2), acc);
            n++;
        end
        wait_drain("random");
        chk("fu_queue_empty", (fu_exp_q.size() == 0), 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
